// File: rtl/timer_slot_scheduler.sv
// timer_slot_scheduler: shared tick counter plus a pool of one-shot deadline timers
// whose expiries drain one at a time in round-robin order on a valid/ready port.
module timer_slot_scheduler #(
  parameter int NUM_SLOTS = 5,
  parameter int CNT_W = 10,
  parameter int TAG_W = 4,
  localparam int SLOT_W = NUM_SLOTS > 1 ? $clog2(NUM_SLOTS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CNT_W-1:0]  req_delay,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [SLOT_W-1:0] req_slot,
  input  logic              cancel_valid,
  input  logic [SLOT_W-1:0] cancel_slot,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [SLOT_W-1:0] evt_slot,
  output logic [TAG_W-1:0]  evt_tag,
  output logic [NUM_SLOTS-1:0] busy_vec,
  output logic [CNT_W-1:0]  cnt_out
);
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_SLOTS-1:0] busy_q, busy_d, pend_q, pend_d;
  logic [CNT_W-1:0]     dl_q [NUM_SLOTS];
  logic [CNT_W-1:0]     dl_d [NUM_SLOTS];
  logic [TAG_W-1:0]     tag_q [NUM_SLOTS];
  logic [TAG_W-1:0]     tag_d [NUM_SLOTS];
  logic [SLOT_W-1:0]    rr_q, rr_d, hold_slot_q, hold_slot_d, sel;
  logic                 hold_q, hold_d, hold_ok, accept, evt_hs;

  assign evt_valid = |pend_q;
  assign busy_vec  = busy_q;
  assign cnt_out   = cnt_q;
  assign req_ready = ~&busy_q;
  assign accept    = req_valid & req_ready;
  assign evt_hs    = evt_valid & evt_ready;

  // A stalled event keeps its slot even if an earlier-in-RR-order slot expires meanwhile.
  always_comb begin
    req_slot = '0;
    sel = '0;
    evt_tag = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      int j;
      j = int'(rr_q) + i;
      j = j >= NUM_SLOTS ? j - NUM_SLOTS : j;
      if (!busy_q[i]) req_slot = SLOT_W'(i);
      if (pend_q[j]) sel = SLOT_W'(j);
    end
    hold_ok = hold_q & pend_q[hold_slot_q];
    evt_slot = hold_ok ? hold_slot_q : sel;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (evt_slot == SLOT_W'(i)) evt_tag = tag_q[i];
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    busy_d = busy_q;
    pend_d = pend_q;
    dl_d = dl_q;
    tag_d = tag_q;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (busy_q[s] && !pend_q[s] && cnt_q == dl_q[s]) pend_d[s] = 1'b1;
      if ((evt_hs && evt_slot == SLOT_W'(s)) || (cancel_valid && cancel_slot == SLOT_W'(s))) begin
        busy_d[s] = 1'b0;
        pend_d[s] = 1'b0;
      end
      if (accept && req_slot == SLOT_W'(s)) begin
        busy_d[s] = 1'b1;
        pend_d[s] = 1'b0;
        dl_d[s] = cnt_q + req_delay;
        tag_d[s] = req_tag;
      end
    end
    rr_d = !evt_hs ? rr_q : evt_slot == SLOT_W'(NUM_SLOTS - 1) ? '0 : evt_slot + 1'b1;
    hold_d = evt_valid & ~evt_ready;
    hold_slot_d = evt_slot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      busy_q <= '0;
      pend_q <= '0;
      rr_q <= '0;
      hold_q <= 1'b0;
      hold_slot_q <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        dl_q[s] <= '0;
        tag_q[s] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      pend_q <= pend_d;
      rr_q <= rr_d;
      hold_q <= hold_d;
      hold_slot_q <= hold_slot_d;
      dl_q <= dl_d;
      tag_q <= tag_d;
    end
  end
endmodule

// File: tb/tb_timer_slot_scheduler.sv
// tb_timer_slot_scheduler: directed vectors with hand-computed expectations.
module tb_timer_slot_scheduler;
  logic       clk = 0, rst_n = 0, req_valid = 0, cancel_valid = 0, evt_ready = 0;
  logic [9:0] req_delay = 0;
  logic [3:0] req_tag = 0;
  logic [2:0] cancel_slot = 0;
  logic       req_ready, evt_valid;
  logic [2:0] req_slot, evt_slot;
  logic [3:0] evt_tag;
  logic [4:0] busy_vec;
  logic [9:0] cnt_out;
  logic [9:0] dly [5] = '{10'd8, 10'd52, 10'd300, 10'd50, 10'd49};
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  timer_slot_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_delay(req_delay),
    .req_tag(req_tag), .req_slot(req_slot),
    .cancel_valid(cancel_valid), .cancel_slot(cancel_slot),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_slot(evt_slot), .evt_tag(evt_tag),
    .busy_vec(busy_vec), .cnt_out(cnt_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int c);
    int n = 0;
    while (int'(cnt_out) != c && n < 2048) begin
      tick();
      n++;
    end
    chk("run_to", cnt_out, c);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cnt"}, cnt_out, 0);
    chk({tag, "_busy"}, busy_vec, 0);
    chk({tag, "_evt_valid"}, evt_valid, 0);
    chk({tag, "_evt_slot"}, evt_slot, 0);
    chk({tag, "_evt_tag"}, evt_tag, 0);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_req_slot"}, req_slot, 0);
  endtask

  initial begin
    #22;
    chk_reset("rst");
    rst_n = 1;
    // single timer, delay 5
    req_valid = 1; req_delay = 5; req_tag = 3;
    chk("t1_slot", req_slot, 0);
    tick();
    req_valid = 0;
    chk("t1_busy", busy_vec, 5'h01);
    chk("t1_cnt", cnt_out, 1);
    repeat (4) tick();
    chk("t1_early", evt_valid, 0);
    tick();
    chk("t1_valid", evt_valid, 1);
    chk("t1_evt_slot", evt_slot, 0);
    chk("t1_evt_tag", evt_tag, 3);
    evt_ready = 1;
    tick();
    evt_ready = 0;
    chk("t1_freed", busy_vec, 0);
    chk("t1_drained", evt_valid, 0);
    // fill all slots, then a stalled sixth request with delay 0
    for (int i = 0; i < 5; i++) begin
      req_valid = 1; req_delay = dly[i]; req_tag = 4'(10 + i);
      chk("t2_slot", req_slot, i);
      tick();
    end
    chk("t2_cnt", cnt_out, 12);
    chk("t2_full", req_ready, 0);
    chk("t2_busy", busy_vec, 5'h1f);
    req_delay = 0; req_tag = 9;
    run_to(15);
    chk("t2_stall_busy", busy_vec, 5'h1f);
    chk("t2_no_evt", evt_valid, 0);
    tick();
    chk("t2_evt_valid", evt_valid, 1);
    chk("t2_evt_slot", evt_slot, 0);
    chk("t2_evt_tag", evt_tag, 10);
    chk("t2_still_full", req_ready, 0);
    evt_ready = 1;
    tick();
    evt_ready = 0;
    chk("t2_freed", busy_vec, 5'h1e);
    chk("t2_ready", req_ready, 1);
    chk("t2_grant", req_slot, 0);
    tick();
    req_valid = 0;
    chk("t2_refill", busy_vec, 5'h1f);
    chk("t2_cnt2", cnt_out, 18);
    // cancels: busy slot, free slot, out-of-range slot, then on the match edge
    cancel_valid = 1; cancel_slot = 2;
    tick();
    chk("t5_cancel", busy_vec, 5'h1b);
    tick();
    chk("t5_cancel_free", busy_vec, 5'h1b);
    cancel_slot = 7;
    tick();
    chk("t5_cancel_oor", busy_vec, 5'h1b);
    cancel_valid = 0;
    chk("t5_grant", req_slot, 2);
    req_valid = 1; req_delay = 5; req_tag = 6;
    tick();
    req_valid = 0;
    chk("t5_realloc", busy_vec, 5'h1f);
    run_to(26);
    cancel_valid = 1; cancel_slot = 2;
    tick();
    cancel_valid = 0;
    chk("t5_match_cancel", evt_valid, 0);
    chk("t5_match_busy", busy_vec, 5'h1b);
    tick();
    chk("t5_no_late_evt", evt_valid, 0);
    // slots 1,3,4 share deadline 60
    run_to(60);
    chk("t4_early", evt_valid, 0);
    tick();
    chk("t4_valid", evt_valid, 1);
    chk("t4_slot1", evt_slot, 1);
    chk("t4_tag1", evt_tag, 11);
    repeat (2) tick();
    chk("t4_hold_slot", evt_slot, 1);
    chk("t4_hold_tag", evt_tag, 11);
    evt_ready = 1;
    tick();
    chk("t4_slot3", evt_slot, 3);
    chk("t4_tag3", evt_tag, 13);
    chk("t4_busy3", busy_vec, 5'h19);
    tick();
    chk("t4_slot4", evt_slot, 4);
    chk("t4_tag4", evt_tag, 14);
    chk("t4_busy4", busy_vec, 5'h11);
    tick();
    evt_ready = 0;
    chk("t4_drained", evt_valid, 0);
    chk("t4_busy_end", busy_vec, 5'h01);
    // deadline wraps: 1020 + 10 -> 6
    run_to(1020);
    chk("t3_grant", req_slot, 1);
    req_valid = 1; req_delay = 10; req_tag = 5;
    tick();
    req_valid = 0;
    chk("t3_busy", busy_vec, 5'h03);
    run_to(6);
    chk("t3_early", evt_valid, 0);
    tick();
    chk("t3_valid", evt_valid, 1);
    chk("t3_slot", evt_slot, 1);
    chk("t3_tag", evt_tag, 5);
    evt_ready = 1;
    tick();
    evt_ready = 0;
    chk("t3_drained", evt_valid, 0);
    chk("t3_busy_end", busy_vec, 5'h01);
    // delay 0 accepted at cnt 17 expires a full wrap later
    run_to(17);
    chk("t6_early", evt_valid, 0);
    tick();
    chk("t6_valid", evt_valid, 1);
    chk("t6_slot", evt_slot, 0);
    chk("t6_tag", evt_tag, 9);
    #2 rst_n = 0;
    #1 chk_reset("arst");
    #3 rst_n = 1;
    tick();
    chk("post_rst_cnt", cnt_out, 1);
    chk("post_rst_evt", evt_valid, 0);
    chk("post_rst_busy", busy_vec, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
